// File: rtl/switch_counter_pkg.sv
// rtl/switch_counter_pkg.sv - shared mode constants and load clamp helper for the switch step counter
package switch_counter_pkg;

    localparam bit MODE_WRAP  = 1'b0;
    localparam bit MODE_SAT   = 1'b1;
    localparam bit STEP_LEVEL = 1'b0;
    localparam bit STEP_EDGE  = 1'b1;
    localparam int DB_CNT_W   = 8;

    function automatic int unsigned clamp_load(input int unsigned value, input int unsigned modulus);
        return (value >= modulus) ? modulus - 1 : value;
    endfunction

endpackage

// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - synchroniser, optional debounce (macro DEBOUNCE_EN) and step detector
module switch_conditioner
    import switch_counter_pkg::*;
#(
    parameter bit EDGE_MODE       = STEP_EDGE,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic step_o
);

    logic sw_s1_q;
    logic sw_s2_q;
    logic lvl;
    logic lvl_prev_q;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** DB_CNT_W) - 1) begin : g_bad_debounce
        $error("switch_conditioner: DEBOUNCE_CYCLES out of range");
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_s1_q    <= 1'b0;
            sw_s2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            sw_s1_q    <= sw_i;
            sw_s2_q    <= sw_s1_q;
            lvl_prev_q <= lvl;
        end
    end

`ifdef DEBOUNCE_EN
    typedef enum logic {STABLE, CHANGING} db_state_e;

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_e           state_q, state_d;
    logic [DB_CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic                lvl_q, lvl_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= STABLE;
            stab_cnt_q <= '0;
            lvl_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            lvl_q      <= lvl_d;
        end
    end

    // The level is accepted on the DEBOUNCE_CYCLES-th consecutive differing clock.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        lvl_d      = lvl_q;
        case (state_q)
            STABLE: begin
                if (sw_s2_q != lvl_q) begin
                    if (CNT_LAST == '0) begin
                        lvl_d = sw_s2_q;
                    end else begin
                        state_d    = CHANGING;
                        stab_cnt_d = DB_CNT_W'(1);
                    end
                end
            end
            CHANGING: begin
                if (sw_s2_q == lvl_q) begin
                    state_d    = STABLE;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == CNT_LAST) begin
                    state_d    = STABLE;
                    stab_cnt_d = '0;
                    lvl_d      = sw_s2_q;
                end else begin
                    stab_cnt_d = stab_cnt_q + DB_CNT_W'(1);
                end
            end
            default: begin
                state_d    = STABLE;
                stab_cnt_d = '0;
            end
        endcase
    end

    assign lvl = lvl_q;
`else
    assign lvl = sw_s2_q;
`endif

    assign step_o = (EDGE_MODE == STEP_LEVEL) ? lvl : (lvl & ~lvl_prev_q);

endmodule

// File: rtl/switch_step_counter.sv
// rtl/switch_step_counter.sv - modulo up/down step counter with load, wrap/saturate, tc and ovf
// Debounce of the switch input is enabled by defining DEBOUNCE_EN.
module switch_step_counter
    import switch_counter_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int MODULUS         = 16,
    parameter bit EDGE_MODE       = STEP_EDGE,
    parameter bit SATURATE        = MODE_WRAP,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             counter_clock,
    input  logic             rst,
    input  logic             switch,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             ovf
);

    if (MODULUS < 2 || (WIDTH < 31 && MODULUS > (1 << WIDTH))) begin : g_bad_modulus
        $error("switch_step_counter: MODULUS out of range for WIDTH");
    end

    localparam logic [WIDTH:0] TOP = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    logic             step;
    logic [WIDTH:0]   counter_q, counter_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH:0]   step_next;
    logic             at_bound;

    switch_conditioner #(
        .EDGE_MODE       (EDGE_MODE),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
        .clk_i  (counter_clock),
        .rst_i  (rst),
        .sw_i   (switch),
        .step_o (step)
    );

    assign load_clamped = WIDTH'(clamp_load(32'(load_value), 32'(MODULUS)));

    // The extra MSB keeps MODULUS == 2**WIDTH representable at the bounds.
    always_comb begin
        step_next = counter_q;
        at_bound  = 1'b0;
        if (up_down) begin
            at_bound  = (counter_q == TOP);
            step_next = at_bound ? ((SATURATE == MODE_SAT) ? TOP : '0) : counter_q + ONE;
        end else begin
            at_bound  = (counter_q == '0);
            step_next = at_bound ? ((SATURATE == MODE_SAT) ? '0 : TOP) : counter_q - ONE;
        end
    end

    always_comb begin
        counter_d = counter_q;
        tc_d      = 1'b0;
        ovf_d     = ovf_q & ~clr_flags;
        if (load) begin
            counter_d = {1'b0, load_clamped};
        end else if (step) begin
            counter_d = step_next;
            if (at_bound) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge counter_clock) begin
        if (rst) begin
            counter_q <= '0;
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign counter = counter_q[WIDTH-1:0];
    assign tc      = tc_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_switch_step_counter.sv
// tb/tb_switch_step_counter.sv - self-checking bench for four switch_step_counter configurations
module tb_switch_step_counter;

    localparam int NDUT = 4;
`ifdef DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       switch = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;
    logic       clr_flags = 1'b0;

    wire [NDUT-1:0][3:0] cnt;
    wire [NDUT-1:0]      tc;
    wire [NDUT-1:0]      ovf;

    int n_cmp = 0;
    int n_bad = 0;

    // Configurations: 0 = M16 edge wrap, 1 = M10 edge wrap, 2 = M10 edge sat, 3 = M16 level wrap
    int m_mod  [NDUT] = '{16, 10, 10, 16};
    bit m_edge [NDUT] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit m_sat  [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int m_cnt  [NDUT];
    bit m_tc   [NDUT];
    bit m_ovf  [NDUT];
    bit hist[$];

    switch_step_counter #(.WIDTH(4), .MODULUS(16), .EDGE_MODE(1'b1), .SATURATE(1'b0), .DEBOUNCE_CYCLES(4)) dut0 (
        .counter_clock(clk), .rst(rst), .switch(switch), .up_down(up_down), .load(load),
        .load_value(load_value), .clr_flags(clr_flags), .counter(cnt[0]), .tc(tc[0]), .ovf(ovf[0]));
    switch_step_counter #(.WIDTH(4), .MODULUS(10), .EDGE_MODE(1'b1), .SATURATE(1'b0), .DEBOUNCE_CYCLES(4)) dut1 (
        .counter_clock(clk), .rst(rst), .switch(switch), .up_down(up_down), .load(load),
        .load_value(load_value), .clr_flags(clr_flags), .counter(cnt[1]), .tc(tc[1]), .ovf(ovf[1]));
    switch_step_counter #(.WIDTH(4), .MODULUS(10), .EDGE_MODE(1'b1), .SATURATE(1'b1), .DEBOUNCE_CYCLES(4)) dut2 (
        .counter_clock(clk), .rst(rst), .switch(switch), .up_down(up_down), .load(load),
        .load_value(load_value), .clr_flags(clr_flags), .counter(cnt[2]), .tc(tc[2]), .ovf(ovf[2]));
    switch_step_counter #(.WIDTH(4), .MODULUS(16), .EDGE_MODE(1'b0), .SATURATE(1'b0), .DEBOUNCE_CYCLES(4)) dut3 (
        .counter_clock(clk), .rst(rst), .switch(switch), .up_down(up_down), .load(load),
        .load_value(load_value), .clr_flags(clr_flags), .counter(cnt[3]), .tc(tc[3]), .ovf(ovf[3]));

    function automatic bit samp(input int j);
        return (j >= 0 && j < hist.size()) ? hist[j] : 1'b0;
    endfunction

    // Reference: a step happens LAT edges after the switch was sampled (rising edge or high level).
    task automatic model_edge();
        if (rst) begin
            hist.delete();
            for (int d = 0; d < NDUT; d++) begin
                m_cnt[d] = 0; m_tc[d] = 1'b0; m_ovf[d] = 1'b0;
            end
        end else begin
            int n;
            n = hist.size();
            for (int d = 0; d < NDUT; d++) begin
                bit st;
                st = m_edge[d] ? (samp(n - LAT) && !samp(n - LAT - 1)) : samp(n - LAT);
                m_tc[d] = 1'b0;
                if (clr_flags) m_ovf[d] = 1'b0;
                if (load) begin
                    m_cnt[d] = (int'(load_value) >= m_mod[d]) ? m_mod[d] - 1 : int'(load_value);
                end else if (st) begin
                    if (up_down) begin
                        if (m_cnt[d] == m_mod[d] - 1) begin
                            m_tc[d] = 1'b1; m_ovf[d] = 1'b1;
                            if (!m_sat[d]) m_cnt[d] = 0;
                        end else m_cnt[d] = m_cnt[d] + 1;
                    end else begin
                        if (m_cnt[d] == 0) begin
                            m_tc[d] = 1'b1; m_ovf[d] = 1'b1;
                            if (!m_sat[d]) m_cnt[d] = m_mod[d] - 1;
                        end else m_cnt[d] = m_cnt[d] - 1;
                    end
                end
            end
            hist.push_back(switch);
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; switch = 1'b0; load = 1'b0; clr_flags = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (cnt[d] !== 4'd0) begin n_bad++; $display("FAIL reset_cnt[%0d]: got %0d want 0", d, cnt[d]); end
            n_cmp++;
            if (tc[d] !== 1'b0) begin n_bad++; $display("FAIL reset_tc[%0d]: got %b want 0", d, tc[d]); end
            n_cmp++;
            if (ovf[d] !== 1'b0) begin n_bad++; $display("FAIL reset_ovf[%0d]: got %b want 0", d, ovf[d]); end
        end
    endtask

    task automatic test_count_up();
        do_reset();
        up_down = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < 8; i++) begin
                int exp;
                switch = (i < 4);
                cyc();
                exp = (i >= LAT) ? k : k - 1;
                n_cmp++;
                if (cnt[0] !== 4'(exp)) begin n_bad++; $display("FAIL count_up k=%0d i=%0d: got %0d want %0d", k, i, cnt[0], exp); end
                n_cmp++;
                if (tc[0] !== 1'b0 || ovf[0] !== 1'b0) begin n_bad++; $display("FAIL count_up_flags: got tc=%b ovf=%b want 0 0", tc[0], ovf[0]); end
            end
        end
    endtask

    task automatic test_wrap_boundary();
        int tc_seen;
        do_reset();
        up_down = 1'b1; load = 1'b1; load_value = 4'd9;
        cyc();
        load = 1'b0;
        n_cmp++;
        if (cnt[1] !== 4'd9 || tc[1] !== 1'b0) begin n_bad++; $display("FAIL wrap_load: got cnt=%0d tc=%b want 9 0", cnt[1], tc[1]); end
        tc_seen = 0;
        for (int i = 0; i < 12; i++) begin
            switch = (i < 4);
            cyc();
            tc_seen += int'(tc[1]);
        end
        n_cmp++;
        if (cnt[1] !== 4'd0) begin n_bad++; $display("FAIL wrap_cnt: got %0d want 0", cnt[1]); end
        n_cmp++;
        if (tc_seen != 1) begin n_bad++; $display("FAIL wrap_tc_cycles: got %0d want 1", tc_seen); end
        n_cmp++;
        if (ovf[1] !== 1'b1) begin n_bad++; $display("FAIL wrap_ovf: got %b want 1", ovf[1]); end
        n_cmp++;
        if (cnt[0] !== 4'd10 || ovf[0] !== 1'b0) begin n_bad++; $display("FAIL wrap_m16: got cnt=%0d ovf=%b want 10 0", cnt[0], ovf[0]); end
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        n_cmp++;
        if (ovf[1] !== 1'b0) begin n_bad++; $display("FAIL wrap_clr: got %b want 0", ovf[1]); end
    endtask

    task automatic test_saturate();
        int tc_seen;
        do_reset();
        up_down = 1'b0;
        tc_seen = 0;
        for (int i = 0; i < 24; i++) begin
            switch = ((i % 8) < 4);
            cyc();
            tc_seen += int'(tc[2]);
        end
        n_cmp++;
        if (cnt[2] !== 4'd0) begin n_bad++; $display("FAIL sat_cnt: got %0d want 0", cnt[2]); end
        n_cmp++;
        if (tc_seen != 3) begin n_bad++; $display("FAIL sat_tc_pulses: got %0d want 3", tc_seen); end
        n_cmp++;
        if (ovf[2] !== 1'b1) begin n_bad++; $display("FAIL sat_ovf: got %b want 1", ovf[2]); end
        n_cmp++;
        if (cnt[1] !== 4'd7) begin n_bad++; $display("FAIL down_wrap_cnt: got %0d want 7", cnt[1]); end
    endtask

    task automatic test_load();
        do_reset();
        load = 1'b1; load_value = 4'd15;
        cyc();
        load = 1'b0;
        n_cmp++;
        if (cnt[1] !== 4'd9 || cnt[2] !== 4'd9) begin n_bad++; $display("FAIL load_clamp: got %0d %0d want 9 9", cnt[1], cnt[2]); end
        n_cmp++;
        if (cnt[0] !== 4'd15) begin n_bad++; $display("FAIL load_full: got %0d want 15", cnt[0]); end
        up_down = 1'b1; switch = 1'b1;
        for (int i = 0; i <= LAT; i++) begin
            load = (i == LAT); load_value = 4'd5;
            cyc();
        end
        load = 1'b0;
        n_cmp++;
        if (cnt[0] !== 4'd5 || tc[0] !== 1'b0) begin n_bad++; $display("FAIL load_step_coincide: got cnt=%0d tc=%b want 5 0", cnt[0], tc[0]); end
        for (int i = 0; i < 10; i++) cyc();
        n_cmp++;
        if (cnt[0] !== 4'd5 || cnt[1] !== 4'd5) begin n_bad++; $display("FAIL load_no_replay: got %0d %0d want 5 5", cnt[0], cnt[1]); end
        switch = 1'b0;
        for (int i = 0; i < LAT + 4; i++) cyc();
    endtask

    task automatic test_level_and_reset();
        do_reset();
        up_down = 1'b1; load = 1'b1; load_value = 4'd2;
        cyc();
        load = 1'b0; switch = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        switch = 1'b0;
        for (int i = 0; i < LAT + 4; i++) cyc();
        n_cmp++;
        if (cnt[3] !== 4'd8) begin n_bad++; $display("FAIL level_cnt: got %0d want 8", cnt[3]); end
        switch = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (cnt[3] !== 4'd0 || cnt[0] !== 4'd0) begin n_bad++; $display("FAIL midpress_reset: got %0d %0d want 0 0", cnt[3], cnt[0]); end
        for (int i = 0; i < LAT + 4; i++) begin
            int exp;
            cyc();
            exp = (i >= LAT) ? i - LAT + 1 : 0;
            n_cmp++;
            if (cnt[3] !== 4'(exp)) begin n_bad++; $display("FAIL midpress_level i=%0d: got %0d want %0d", i, cnt[3], exp); end
        end
        n_cmp++;
        if (cnt[0] !== 4'd1) begin n_bad++; $display("FAIL midpress_edge: got %0d want 1", cnt[0]); end
        switch = 1'b0;
    endtask

`ifdef DEBOUNCE_EN
    task automatic test_debounce();
        do_reset();
        up_down = 1'b1;
        for (int i = 0; i < 15; i++) begin
            switch = (i < 3);
            cyc();
        end
        n_cmp++;
        if (cnt[0] !== 4'd0) begin n_bad++; $display("FAIL debounce_glitch: got %0d want 0", cnt[0]); end
        for (int i = 0; i < 16; i++) begin
            switch = (i < 10);
            cyc();
            if (i == LAT - 1) begin
                n_cmp++;
                if (cnt[0] !== 4'd0) begin n_bad++; $display("FAIL debounce_early: got %0d want 0", cnt[0]); end
            end
            if (i == LAT) begin
                n_cmp++;
                if (cnt[0] !== 4'd1) begin n_bad++; $display("FAIL debounce_e6: got %0d want 1", cnt[0]); end
            end
        end
        n_cmp++;
        if (cnt[0] !== 4'd1) begin n_bad++; $display("FAIL debounce_single: got %0d want 1", cnt[0]); end
    endtask
`endif

    task automatic test_random();
        int phase_left;
        do_reset();
        phase_left = 0;
        for (int c = 0; c < 400; c++) begin
            if (phase_left == 0) begin
                switch = ~switch;
                phase_left = $urandom_range(8, 12);
            end
            phase_left--;
            up_down    = 1'($urandom);
            load       = (($urandom % 16) == 0);
            load_value = 4'($urandom);
            clr_flags  = (($urandom % 8) == 0);
            cyc();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (cnt[d] !== 4'(m_cnt[d]) || tc[d] !== m_tc[d] || ovf[d] !== m_ovf[d]) begin
                    n_bad++;
                    $display("FAIL random c=%0d dut%0d: got cnt=%0d tc=%b ovf=%b want cnt=%0d tc=%b ovf=%b",
                             c, d, cnt[d], tc[d], ovf[d], m_cnt[d], m_tc[d], m_ovf[d]);
                end
            end
        end
        load = 1'b0; clr_flags = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_boundary();
        test_saturate();
        test_load();
        test_level_and_reset();
`ifdef DEBOUNCE_EN
        test_debounce();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
